// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues level-held imem requests and presents one
// fetched word at a time to decode over valid/ready, with redirect-driven wrong-path flush.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [6:0]         if_opcode,
    output logic [31:0]        if_pc,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [COUNT_W-1:0] fetch_count,
    output logic [1:0]         state_dbg
);

    // Handshake: a word moves to decode in any cycle where if_valid & id_ready at the clock edge;
    // if_valid/if_instr/if_pc hold while if_valid & !id_ready & !redirect_valid.
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FULL = 2'd2} state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] held_addr;
    logic        discard;
    logic [31:0] redir_aligned;

    assign redir_aligned = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fetch_en) state_next = FETCH;
            FETCH: if (imem_rvalid && !discard && !redirect_valid) state_next = FULL;
            FULL:  if (redirect_valid || id_ready) state_next = fetch_en ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // While a stale response is still owed, the old address stays on the bus.
    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = discard ? held_addr : pc;
        if_opcode = if_instr[6:0];
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            held_addr   <= '0;
            discard     <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) pc <= redir_aligned;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc <= redir_aligned;
                        if (imem_rvalid) begin
                            discard <= 1'b0;
                        end else if (!discard) begin
                            discard   <= 1'b1;
                            held_addr <= pc;
                        end
                    end else if (imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                        end
                    end
                end
                FULL: begin
                    if (id_ready)
                        fetch_count <= fetch_count + {{(COUNT_W-1){1'b0}}, 1'b1};
                    if (redirect_valid || id_ready) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                    end
                    if (redirect_valid) pc <= redir_aligned;
                end
                default: ;
            endcase
        end
    end

endmodule
